// File: rtl/demux3_stream.sv
// rtl/demux3_stream.sv - one-word buffered 1:3 stream demux with per-port transfer counters
module demux3_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             cnt_clr,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [1:0]       dest;
  logic [WIDTH-1:0] data_q;

  logic       rsel;
  logic       xfer;
  logic       accept;
  logic [1:0] s_dec;

  // Select 10 and 11 both route to port 2.
  assign s_dec = s[1] ? 2'd2 : {1'b0, s[0]};

  // Ready of the port the held word is waiting on.
  always_comb begin
    rsel = r2;
    case (dest)
      2'd0:    rsel = r0;
      2'd1:    rsel = r1;
      default: rsel = r2;
    endcase
  end

  assign xfer     = (state == FULL) && rsel;
  assign in_ready = (state == EMPTY) || rsel;
  assign accept   = in_valid && in_ready;

  assign v0 = (state == FULL) && (dest == 2'd0);
  assign v1 = (state == FULL) && (dest == 2'd1);
  assign v2 = (state == FULL) && (dest == 2'd2);

  assign y0 = v0 ? data_q : '0;
  assign y1 = v1 ? data_q : '0;
  assign y2 = v2 ? data_q : '0;

  // Buffer state: a simultaneous drain and accept reloads, so the pipe sustains one word per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      dest   <= 2'd0;
      data_q <= '0;
    end else if (accept) begin
      state  <= FULL;
      dest   <= s_dec;
      data_q <= d;
    end else if (xfer) begin
      state  <= EMPTY;
    end
  end

  // Saturating transfer counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
      cnt2 <= 8'd0;
    end else if (cnt_clr) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
      cnt2 <= 8'd0;
    end else begin
      if (v0 && r0 && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      if (v1 && r1 && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
      if (v2 && r2 && cnt2 != 8'hFF) cnt2 <= cnt2 + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux3_stream.sv
// tb/tb_demux3_stream.sv - directed self-checking bench for demux3_stream
module tb_demux3_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic [1:0] s;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y0, y1, y2;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic       cnt_clr;
  logic [7:0] cnt0, cnt1, cnt2;

  int nvec = 0;
  int nerr = 0;

  demux3_stream #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .v0(v0), .v1(v1), .v2(v2),
    .r0(r0), .r1(r1), .r2(r2), .cnt_clr(cnt_clr),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; d = '0; s = '0; in_valid = 1'b0; cnt_clr = 1'b0;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_v", {v0, v1, v2}, 0);
    check("rst_y", {y0, y1, y2}, 0);
    check("rst_cnt", {cnt0, cnt1, cnt2}, 0);
    step();
    reset = 1'b0;

    // single route to port 1
    d = 8'hA5; s = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("route_v1", v1, 1);
    check("route_y1", y1, 8'hA5);
    check("route_other_v", {v0, v2}, 0);
    check("route_other_y", {y0, y2}, 0);
    check("route_cnt1_pre", cnt1, 0);
    step();
    check("route_cnt1", cnt1, 1);
    check("route_empty_v", {v0, v1, v2}, 0);
    check("route_empty_rdy", in_ready, 1);

    // select 11 goes to port 2
    d = 8'h3C; s = 2'b11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("sel11_v", {v0, v1, v2}, 3'b001);
    check("sel11_y2", y2, 8'h3C);
    step();
    check("sel11_cnt2", cnt2, 1);

    // backpressure on port 0, with a blocked word offered to port 1
    r0 = 1'b0;
    d = 8'h11; s = 2'b00; in_valid = 1'b1;
    step();
    d = 8'h22; s = 2'b01;
    for (int i = 0; i < 4; i++) begin
      check("bp_v0", v0, 1);
      check("bp_y0", y0, 8'h11);
      check("bp_rdy", in_ready, 0);
      check("bp_v1", v1, 0);
      step();
    end
    in_valid = 1'b0;
    r0 = 1'b1;
    step();
    check("bp_cnt0", cnt0, 1);
    check("bp_drain_v0", v0, 0);

    // clear counters with nothing in flight
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_cnt", {cnt0, cnt1, cnt2}, 0);

    // streaming, one word per cycle, selects 00,01,10
    for (int i = 0; i < 9; i++) begin
      logic [2:0] ev;
      d = 8'h40 + 8'(i); s = 2'(i % 3); in_valid = 1'b1;
      check("st_rdy", in_ready, 1);
      step();
      ev = (i % 3 == 0) ? 3'b100 : (i % 3 == 1) ? 3'b010 : 3'b001;
      check("st_v", {v0, v1, v2}, ev);
      check("st_y", (i % 3 == 0) ? y0 : (i % 3 == 1) ? y1 : y2, 8'h40 + 8'(i));
    end
    in_valid = 1'b0;
    step();
    check("st_cnt0", cnt0, 3);
    check("st_cnt1", cnt1, 3);
    check("st_cnt2", cnt2, 3);

    // saturation on port 2
    for (int i = 0; i < 300; i++) begin
      d = 8'(i); s = 2'b10; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    check("sat_cnt2", cnt2, 255);
    d = 8'h77; s = 2'b10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("sat_hold_v2", v2, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_xfer_cnt2", cnt2, 0);
    check("clr_xfer_cnt0", cnt0, 0);
    check("clr_xfer_v2", v2, 0);

    // reset mid-operation
    d = 8'h01; s = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("mid_cnt0_pre", cnt0, 1);
    r1 = 1'b0;
    d = 8'h99; s = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_v1_held", v1, 1);
    check("mid_rdy_held", in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_v1", v1, 0);
    check("mid_y1", y1, 0);
    check("mid_cnt", {cnt0, cnt1, cnt2}, 0);
    check("mid_rdy", in_ready, 1);
    #1;
    reset = 1'b0;
    r1 = 1'b1;

    // first edge after reset accepts normally
    d = 8'h5A; s = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_v", {v0, v1, v2}, 3'b100);
    check("post_y0", y0, 8'h5A);
    step();
    check("post_cnt", {cnt0, cnt1, cnt2}, {8'd1, 8'd0, 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/demux3_stream.md
DEMUX3_STREAM -- requirements
Module: demux3_stream

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the data width of the input and every output port.
REQ-002 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 d  input  WIDTH  Input data word.
REQ-005 s  input  2  Destination select: 00 -> port 0, 01 -> port 1, 10 or 11 -> port 2.
REQ-006 in_valid  input  1  Input word and select are valid this cycle.
REQ-007 in_ready  output  1  Block can accept an input word this cycle.
REQ-008 y0, y1, y2  output  WIDTH each  Per-port output data.
REQ-009 v0, v1, v2  output  1 each  Per-port output valid.
REQ-010 r0, r1, r2  input  1 each  Per-port downstream ready.
REQ-011 cnt_clr  input  1  Synchronous clear of all transfer counters.
REQ-012 cnt0, cnt1, cnt2  output  8 each  Per-port completed-transfer counts.

Function
REQ-013 The block SHALL hold at most one word in a single registered buffer, with state EMPTY or FULL plus a 2-bit destination index dest in {0,1,2}.
REQ-014 The input handshake SHALL complete (accept) in any cycle where in_valid && in_ready.
REQ-015 in_ready SHALL be 1 in EMPTY; in FULL it SHALL equal r[dest], the ready of the held word's port; it SHALL be combinational and SHALL NOT depend on in_valid.
REQ-016 On accept, the buffer SHALL capture d on that clock edge, and dest SHALL capture the decode of s per REQ-005 on the same edge.
REQ-017 vK SHALL be 1 only when state is FULL and dest==K; at most one of v0..v2 SHALL be 1 in any cycle.
REQ-018 yK SHALL equal the buffered word when vK=1, and SHALL be all-zero otherwise.
REQ-019 An output transfer on port K SHALL occur in a cycle where vK && rK.
REQ-020 Latency SHALL be exactly one cycle: a word accepted at edge N SHALL present its valid from edge N onward (visible in cycle N+1).
REQ-021 EMPTY with accept SHALL go to FULL.
REQ-022 FULL with transfer and no accept SHALL go to EMPTY.
REQ-023 FULL with transfer and a simultaneous accept SHALL stay FULL and load the new word and dest, giving one word per cycle.
REQ-024 FULL with no transfer SHALL hold the buffered word, dest, and vK stable; no accept is possible because in_ready=0.
REQ-025 A word routed to port K SHALL NOT be blocked by backpressure on any other port, except through the single shared buffer.
REQ-026 On each transfer on port K, cntK SHALL increment by 1 and SHALL saturate at 255 (no wrap).
REQ-027 cnt_clr=1 SHALL zero all three counters, taking priority over a same-cycle increment; it SHALL NOT affect the buffer or the handshake.
REQ-028 in_valid with in_ready=0 SHALL have no effect on state; the upstream holds d and s.

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for clk, force state EMPTY, dest=0, v0..v2=0, y0..y2=0, and cnt0..cnt2=0; with no reset-time dependence on inputs, in_ready SHALL be 1.
REQ-030 A word held when reset asserts mid-operation SHALL be discarded and not counted.
REQ-031 After reset deasserts, the first rising edge SHALL already accept input normally.

Verification
REQ-032 Single route: reset, then d=8'hA5, s=01, in_valid=1 for 1 cycle, all r=1 -> next cycle v1=1, y1=A5, y0=y2=0, v0=v2=0; following cycle cnt1=1 and the block is EMPTY.
REQ-033 Select 11: d=8'h3C, s=11 -> word appears on port 2 only, with cnt2=1.
REQ-034 Backpressure: load 8'h11 to port 0 with r0=0 for 4 cycles -> v0 and y0=11 stable, in_ready=0; raise r0 -> transfer, cnt0=1.
REQ-035 Streaming: in_valid=1 every cycle with s cycling 00,01,10, all r=1, 9 words -> in_ready stays 1, each word appears exactly once on the correct port in order, cnt0=cnt1=cnt2=3.
REQ-036 Saturation and clear: 300 transfers to port 2 -> cnt2=255; then cnt_clr=1 asserted in the same cycle as a transfer -> cnt2=0.
REQ-037 Reset mid-operation: hold a word with r1=0, assert reset between edges -> v1=0 and y1=0 immediately, counters 0, in_ready=1.
